// File: rtl/prog_loader_pkg.sv
// Shared CPU-side definitions for the program loader: default geometry,
// loader FSM encoding and a saturating counter helper.
package prog_loader_pkg;

  localparam int unsigned MEM_DEPTH_DEF = 32;
  localparam int unsigned ADDR_W_DEF    = 5;
  localparam int unsigned DATA_W_DEF    = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_RELEASE = 3'd2;
  localparam logic [2:0] ST_RUN     = 3'd3;
  localparam logic [2:0] ST_HALTED  = 3'd4;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Streams a program image into external memory, holds the CPU in reset while
// loading, releases it, then tracks run time and the PC at which it halts.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned MEM_DEPTH  = MEM_DEPTH_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned RST_CYCLES = 2
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  input  logic [ADDR_W-1:0] cpu_pc,
  input  logic              cpu_halt,
  output logic              cpu_rst_,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] halt_pc,
  output logic [15:0]       run_cycles
);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [15:0]       rls_q, rls_d;
  logic [ADDR_W-1:0] halt_pc_q, halt_pc_d;
  logic [15:0]       run_q, run_d;
  logic              halt_prev_q;
  logic              halt_rise;

  assign halt_rise = cpu_halt & ~halt_prev_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rls_d     = rls_q;
    halt_pc_d = halt_pc_q;
    run_d     = run_q;
    ld_ready  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_write = 1'b0;
    mem_read  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ld_start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end

      ST_LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          mem_write = 1'b1;
          mem_addr  = cnt_q;
          mem_wdata = ld_data;
        end
        // A restart still writes the handshaked byte but does not count it
        if (ld_start) begin
          cnt_d = '0;
        end else if (ld_valid) begin
          if (cnt_q == ADDR_W'(MEM_DEPTH - 1)) begin
            state_d = ST_RELEASE;
            cnt_d   = '0;
            rls_d   = '0;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end

      ST_RELEASE: begin
        if (ld_start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end else if ((32'(rls_q) + 32'd1) >= RST_CYCLES) begin
          state_d = ST_RUN;
        end else begin
          rls_d = rls_q + 16'd1;
        end
      end

      ST_RUN, ST_HALTED: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_write = cpu_wr;
        mem_read  = cpu_rd;
        if (state_q == ST_RUN) begin
          run_d = sat_inc16(run_q);
        end
        // Abort takes priority over a coincident halt edge
        if (ld_start) begin
          state_d   = ST_LOAD;
          cnt_d     = '0;
          run_d     = '0;
          halt_pc_d = '0;
        end else if (state_q == ST_RUN && halt_rise) begin
          state_d   = ST_HALTED;
          halt_pc_d = cpu_pc;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rls_q       <= '0;
      halt_pc_q   <= '0;
      run_q       <= '0;
      halt_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rls_q       <= rls_d;
      halt_pc_q   <= halt_pc_d;
      run_q       <= run_d;
      halt_prev_q <= cpu_halt;
    end
  end

  assign cpu_rst_   = (state_q == ST_RUN) || (state_q == ST_HALTED);
  assign busy       = (state_q == ST_LOAD) || (state_q == ST_RELEASE);
  assign done       = (state_q == ST_HALTED);
  assign halt_pc    = halt_pc_q;
  assign run_cycles = run_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a byte memory and a tiny fetch-only CPU
// that halts on opcode 8'hFF.
module tb_prog_loader;

  logic        clock = 1'b0;
  logic        rst, ld_start, ld_valid, ld_ready;
  logic [7:0]  ld_data;
  logic [4:0]  cpu_addr, cpu_pc;
  logic [7:0]  cpu_wdata;
  logic        cpu_wr, cpu_rd, cpu_halt, cpu_rst_;
  logic [4:0]  mem_addr, halt_pc;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_write, mem_read, busy, done;
  logic [15:0] run_cycles;

  logic        force_halt;
  logic [4:0]  pc_q   = '0;
  logic        halt_m = 1'b0;
  logic [7:0]  mem [32] = '{default: 8'h00};
  int          wr_cnt = 0;
  int          n_cmp  = 0;
  int          n_fail = 0;
  int          base;
  logic [7:0]  img1 [32];
  logic [7:0]  img2 [32];

  always #5 clock = ~clock;

  prog_loader #(.MEM_DEPTH(32), .ADDR_W(5), .DATA_W(8), .RST_CYCLES(2)) dut (
    .clock(clock), .rst(rst), .ld_start(ld_start), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_ready(ld_ready), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_pc(cpu_pc),
    .cpu_halt(cpu_halt), .cpu_rst_(cpu_rst_), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read),
    .busy(busy), .done(done), .halt_pc(halt_pc), .run_cycles(run_cycles)
  );

  assign mem_rdata = mem[mem_addr];
  assign cpu_addr  = pc_q;
  assign cpu_pc    = pc_q;
  assign cpu_halt  = halt_m | force_halt;

  always @(posedge clock) begin
    if (mem_write) begin
      mem[mem_addr] <= mem_wdata;
      wr_cnt        <= wr_cnt + 1;
    end
  end

  always @(posedge clock) begin
    if (!cpu_rst_) begin
      pc_q   <= '0;
      halt_m <= 1'b0;
    end else if (!halt_m) begin
      if (mem_read && mem_rdata == 8'hFF) halt_m <= 1'b1;
      else pc_q <= pc_q + 5'd1;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      img1[i] = 8'h10 + 8'(i);
      img2[i] = 8'h80 + 8'(3 * i);
    end
    img1[23] = 8'hFF;

    rst = 1'b1; ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0;
    cpu_wr = 1'b0; cpu_rd = 1'b1; cpu_wdata = '0; force_halt = 1'b0;
    tick(); tick();
    rst = 1'b0; cpu_wr = 1'b1;
    #1;
    chk("rst_cpu_rst_", cpu_rst_, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_halt_pc", halt_pc, 0);
    chk("rst_run_cycles", run_cycles, 0);
    cpu_wr = 1'b0;

    // Back-to-back load of the CPUtest1 image
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    base = wr_cnt;
    for (int i = 0; i < 32; i++) begin
      ld_valid = 1'b1; ld_data = img1[i];
      #1;
      chk("b2b_write", mem_write, 1);
      chk("b2b_addr", mem_addr, 32'(i));
      chk("b2b_wdata", mem_wdata, img1[i]);
      chk("b2b_busy", busy, 1);
      chk("b2b_cpu_rst_", cpu_rst_, 0);
      chk("b2b_read", mem_read, 0);
      tick();
    end
    ld_data = 8'hEE;
    #1;
    chk("rel1_busy", busy, 1);
    chk("rel1_no_33rd_write", mem_write, 0);
    chk("rel1_cpu_rst_", cpu_rst_, 0);
    chk("rel1_ld_ready", ld_ready, 0);
    tick();
    chk("rel2_busy", busy, 1);
    chk("rel2_cpu_rst_", cpu_rst_, 0);
    chk("rel2_no_write", mem_write, 0);
    ld_valid = 1'b0;
    tick();
    chk("run_cpu_rst_", cpu_rst_, 1);
    chk("run_busy", busy, 0);
    chk("run_read_pass", mem_read, 1);
    chk("b2b_write_count", wr_cnt - base, 32);
    for (int i = 0; i < 32; i++) chk("b2b_mem", mem[i], img1[i]);

    // Full run until the CPU fetches the halt opcode at 0x17
    for (int k = 0; k < 100 && !done; k++) tick();
    chk("run_done", done, 1);
    chk("run_halt_pc", halt_pc, 5'h17);
    chk("run_cycles", run_cycles, 25);
    tick(); tick();
    chk("halted_run_hold", run_cycles, 25);
    chk("halted_pc_hold", halt_pc, 5'h17);
    chk("halted_cpu_rst_", cpu_rst_, 1);
    cpu_wr = 1'b1; cpu_wdata = 8'hFF;
    #1;
    chk("halted_wr_pass", mem_write, 1);
    chk("halted_addr_pass", mem_addr, 5'h17);
    cpu_wr = 1'b0;

    // Abort from HALTED, then a load with a gap every other cycle
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    #1;
    chk("abort_ld_ready", ld_ready, 1);
    chk("abort_cpu_rst_", cpu_rst_, 0);
    chk("abort_done", done, 0);
    chk("abort_halt_pc", halt_pc, 0);
    chk("abort_run_cycles", run_cycles, 0);
    base = wr_cnt;
    for (int i = 0; i < 64; i++) begin
      ld_valid = (i % 2 == 0);
      ld_data  = img2[i / 2];
      #1;
      chk("gap_write", mem_write, ld_valid);
      if (ld_valid) chk("gap_addr", mem_addr, 32'(i / 2));
      tick();
    end
    ld_valid = 1'b0;
    tick();
    chk("gap_run_cpu_rst_", cpu_rst_, 1);
    chk("gap_write_count", wr_cnt - base, 32);
    for (int i = 0; i < 32; i++) chk("gap_mem", mem[i], img2[i]);

    // Abort while running
    tick(); tick();
    chk("run2_cycles", run_cycles, 2);
    ld_start = 1'b1; cpu_wr = 1'b1; cpu_wdata = 8'h33;
    #1;
    chk("run2_wr_pass", mem_write, 1);
    tick(); ld_start = 1'b0;
    #1;
    chk("run_abort_cpu_rst_", cpu_rst_, 0);
    chk("run_abort_cycles", run_cycles, 0);
    chk("run_abort_wr_block", mem_write, 0);
    chk("run_abort_rd_block", mem_read, 0);
    chk("run_abort_ld_ready", ld_ready, 1);
    ld_valid = 1'b1; ld_data = 8'h5A;
    #1;
    chk("run_abort_addr0", mem_addr, 0);
    chk("run_abort_wdata", mem_wdata, 8'h5A);
    chk("run_abort_write", mem_write, 1);
    tick();

    // Restart during LOAD: byte written at 1, next byte goes to 0
    ld_start = 1'b1; ld_data = 8'h66;
    #1;
    chk("restart_addr", mem_addr, 1);
    tick(); ld_start = 1'b0; ld_data = 8'h77;
    #1;
    chk("restart_addr0", mem_addr, 0);
    tick(); ld_valid = 1'b0; cpu_wr = 1'b0;
    chk("restart_mem1", mem[1], 8'h66);
    chk("restart_mem0", mem[0], 8'h77);

    // Reset mid-load after 10 bytes
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ld_valid = 1'b1; ld_data = 8'(i); tick();
    end
    ld_valid = 1'b0; rst = 1'b1;
    #1;
    chk("midrst_cpu_rst_", cpu_rst_, 0);
    tick(); rst = 1'b0; ld_valid = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_ld_ready", ld_ready, 0);
    chk("midrst_write", mem_write, 0);
    chk("midrst_idle_cpu_rst_", cpu_rst_, 0);
    chk("midrst_mem_kept", mem[5], 8'h05);
    tick(); ld_start = 1'b1; ld_valid = 1'b0;
    #1;
    chk("midrst_start_cpu_rst_", cpu_rst_, 0);
    tick(); ld_start = 1'b0; ld_valid = 1'b1; ld_data = 8'hC3;
    #1;
    chk("midrst_addr0", mem_addr, 0);
    chk("midrst_write0", mem_write, 1);
    chk("midrst_load_cpu_rst_", cpu_rst_, 0);
    tick(); ld_valid = 1'b0;

    // ld_start coincident with a halt edge
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ld_valid = 1'b1; ld_data = img2[i]; tick();
    end
    ld_valid = 1'b0;
    tick(); tick();
    chk("coin_run", cpu_rst_, 1);
    tick(); tick(); tick();
    force_halt = 1'b1; ld_start = 1'b1;
    tick(); force_halt = 1'b0; ld_start = 1'b0;
    #1;
    chk("coin_ld_ready", ld_ready, 1);
    chk("coin_busy", busy, 1);
    chk("coin_done", done, 0);
    chk("coin_halt_pc", halt_pc, 0);
    chk("coin_cpu_rst_", cpu_rst_, 0);
    tick();
    chk("coin_done_after", done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
